// File: rtl/bumpy_pkg.sv
// Shared definitions for the Bumpy player state machine and the movement block.
// The state encoding is fixed because the movement block decodes it directly.
package bumpy_pkg;

  typedef enum logic [3:0] {
    Sreset             = 4'd0,
    Sidle              = 4'd1,
    Sleft              = 4'd2,
    Sright             = 4'd3,
    Sdown              = 4'd4,
    Sup                = 4'd5,
    Sdie               = 4'd6,
    Sbounce_from_left  = 4'd7,
    Sbounce_from_right = 4'd8,
    Sbounce_from_top   = 4'd9
  } bumpy_state_t;

  localparam int MAX_LIVES = 3;

  // States whose duration is measured in frames by the shared frame timer.
  function automatic logic is_timed(input bumpy_state_t s);
    return (s == Sdie) || (s == Sbounce_from_left) ||
           (s == Sbounce_from_right) || (s == Sbounce_from_top);
  endfunction

endpackage

// File: rtl/bumpy_frame_timer.sv
// Counts start-of-frame pulses spent in a timed state; done flags the frame
// on which the state must be left.
module bumpy_frame_timer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  // The count lags the frame index by one, so a state entered at SOF k sees
  // count == limit-1 at SOF k+limit.
  assign done = (count_q == (limit - 8'd1));

endmodule

// File: rtl/bumpy_fsm.sv
// Bumpy player game-logic FSM: turns keys and per-frame collision hits into
// the player state, and tracks lives and game over.
module bumpy_fsm
  import bumpy_pkg::*;
#(
  parameter int BOUNCE_FRAMES = 8,
  parameter int DIE_FRAMES    = 60,
  parameter int LIVES         = 3
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startOfFrame,
  input  logic         start_game,
  input  logic         key_left,
  input  logic         key_right,
  input  logic         key_up,
  input  logic         key_down,
  input  logic         col_deadly,
  input  logic         col_left,
  input  logic         col_right,
  input  logic         col_top,
  output bumpy_state_t state,
  output logic [1:0]   lives_left,
  output logic         game_over
);

  localparam logic [1:0] LIVES_INIT = (LIVES > MAX_LIVES) ? 2'(MAX_LIVES) : 2'(LIVES);

  bumpy_state_t state_q, state_d, move_next;
  logic [1:0]   lives_q;
  logic         game_over_q;
  logic [3:0]   col_q;
  logic [3:0]   col_in, col_eff;
  logic         dir_held;
  logic         timer_clear, timer_en, timer_done;
  logic [7:0]   timer_limit;

  // Bit order {deadly, left, right, top} matches the decision priority.
  assign col_in  = {col_deadly, col_left, col_right, col_top};
  assign col_eff = col_q | col_in;

  assign dir_held = ((state_q == Sleft)  && key_left)  ||
                    ((state_q == Sright) && key_right) ||
                    ((state_q == Sup)    && key_up)    ||
                    ((state_q == Sdown)  && key_down);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    move_next = Sidle;
    if (col_eff[3])      move_next = Sdie;
    else if (col_eff[2]) move_next = Sbounce_from_left;
    else if (col_eff[1]) move_next = Sbounce_from_right;
    else if (col_eff[0]) move_next = Sbounce_from_top;
    else if (dir_held)   move_next = state_q;
    else if (key_left)   move_next = Sleft;
    else if (key_right)  move_next = Sright;
    else if (key_up)     move_next = Sup;
    else if (key_down)   move_next = Sdown;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Sreset: begin
        if (startOfFrame && start_game) state_d = Sidle;
      end
      Sidle, Sleft, Sright, Sup, Sdown: begin
        if (startOfFrame) state_d = move_next;
      end
      Sbounce_from_left, Sbounce_from_right, Sbounce_from_top: begin
        if (startOfFrame) begin
          if (col_eff[3])      state_d = Sdie;
          else if (timer_done) state_d = Sidle;
        end
      end
      Sdie: begin
        if (startOfFrame && timer_done) state_d = (lives_q == 2'd0) ? Sreset : Sidle;
      end
      // Corrupted encodings recover without waiting for a frame boundary.
      default: state_d = Sreset;
    endcase
  end

  assign timer_clear = (state_d != state_q);
  assign timer_en    = startOfFrame && is_timed(state_q);
  assign timer_limit = (state_q == Sdie) ? 8'(DIE_FRAMES) : 8'(BOUNCE_FRAMES);

  bumpy_frame_timer u_timer (
    .clk    (clk),
    .resetN (resetN),
    .clear  (timer_clear),
    .en     (timer_en),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= Sreset;
      lives_q     <= 2'd0;
      game_over_q <= 1'b0;
      col_q       <= 4'd0;
    end else begin
      state_q <= state_d;
      // A hit coinciding with SOF is used via col_eff and then dropped.
      col_q   <= startOfFrame ? 4'd0 : (col_q | col_in);
      if (state_q == Sreset && state_d == Sidle) begin
        lives_q     <= LIVES_INIT;
        game_over_q <= 1'b0;
      end else if (state_d == Sdie && state_q != Sdie) begin
        lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
      end else if (state_q == Sdie && state_d == Sreset) begin
        game_over_q <= 1'b1;
      end
    end
  end

  assign state      = state_q;
  assign lives_left = lives_q;
  assign game_over  = game_over_q;

endmodule

// File: doc/bumpy_fsm.md
# bumpy_fsm

Game-logic state machine for the Bumpy player sprite. Sits directly upstream of the movement block: it turns keyboard levels and per-pixel collision hits into the 4-bit player state that the movement block converts into X/Y speed and position. Decisions are taken once per video frame (on `startOfFrame`). Bounce and death durations are timed in frames, and the block tracks remaining lives.

## Interface
Parameters:
- `BOUNCE_FRAMES`, 8: frames spent in any bounce state (1..255).
- `DIE_FRAMES`, 60: frames spent in `Sdie` (1..255).
- `LIVES`, 3: lives loaded at game start (1..3).

Ports:
- `clk`  in  1: system clock. One clock domain.
- `resetN`  in  1: asynchronous, active-low reset.
- `startOfFrame`  in  1: one-cycle pulse per frame (30 Hz).
- `start_game`  in  1: level. Acted on only in `Sreset`.
- `key_left`, `key_right`, `key_up`, `key_down`  in  1 each: key-held levels.
- `col_deadly`, `col_left`, `col_right`, `col_top`  in  1 each: collision hit pulses from the drawing path. Any cycle within the frame counts.
- `state`  out  4: `bumpy_state_t`, registered.
- `lives_left`  out  2: registered remaining lives.
- `game_over`  out  1: registered; high after the last life is lost.

## Operation
- State encoding (fixed, shared with the movement block): Sreset=0, Sidle=1, Sleft=2, Sright=3, Sdown=4, Sup=5, Sdie=6, Sbounce_from_left=7, Sbounce_from_right=8, Sbounce_from_top=9. Values 10–15 are illegal and recover to Sreset on the next clock.
- Collision latches: four sticky flags.
  - Each flag is set by its `col_*` input on any clock.
  - All four are cleared on every clock where `startOfFrame`=1.
  - The effective flag used for a decision is latch OR the current-cycle input.
- Transitions are evaluated only on clocks with `startOfFrame`=1. On all other clocks the state holds.
- Sreset: `start_game`=1 → Sidle. This also loads `lives_left`=LIVES and clears `game_over`.
- Sidle / Sleft / Sright / Sup / Sdown use one priority list, first match wins:
  1. deadly → Sdie
  2. left → Sbounce_from_left
  3. right → Sbounce_from_right
  4. top → Sbounce_from_top
  5. current direction's key still held → stay
  6. key_left → Sleft
  7. key_right → Sright
  8. key_up → Sup
  9. key_down → Sdown
  10. otherwise → Sidle
- Bounce states:
  - deadly → Sdie.
  - Other collisions are ignored, so a bounce cannot re-trigger.
  - After BOUNCE_FRAMES frames → Sidle.
- Sdie:
  - On entry, `lives_left` decrements by 1, saturating at 0.
  - All inputs are ignored while in Sdie.
  - After DIE_FRAMES frames: if `lives_left`=0 → Sreset and set `game_over`=1; else → Sidle.
- Frame timer, 8-bit:
  - Cleared on every state change.
  - Increments on each SOF while in a timed state.
  - A timed state entered at SOF k exits at SOF k+N (N = BOUNCE_FRAMES or DIE_FRAMES).

## Timing
- Reset values: `state`=Sreset, `lives_left`=0, `game_over`=0, latches=0, timer=0.
- Latency: `state` updates on the clock edge that samples `startOfFrame`=1, so the new value is visible the following cycle. The movement block therefore applies the new speed from the next frame's integration onward.
- Collision pulse in the same cycle as `startOfFrame`: it counts toward this frame's decision and is not carried into the next frame.
- Collision pulse one cycle after `startOfFrame`: it is latched and decided at the next SOF.
- Multiple collisions in one frame: resolved by the priority list only. The unused flags are discarded at the clear.
- `resetN` asserted mid-bounce or mid-die: immediate return to reset values. No partial frame count survives.
- `start_game` held through a whole game: re-entering Sreset with it still high starts a new game at the next SOF.

## Structure
- Package `bumpy_pkg` holds:
  - typedef `bumpy_state_t` (enum logic [3:0], encoding above), shared with the movement block;
  - constant `MAX_LIVES`=3.
- Sub-module `bumpy_frame_timer`: 8-bit SOF counter with synchronous `clear`, `en`, and a `done` compare against a runtime limit. It is instantiated once and muxed between BOUNCE_FRAMES and DIE_FRAMES by state.
- Collision latches and the next-state logic live in the top module.

## Test plan
- Reset, then hold `start_game`=1 across one SOF → `state`=Sidle, `lives_left`=3, `game_over`=0.
- In Sidle, hold `key_right`=1 and `key_left`=1 across SOF → Sleft. Then release `key_left` at the next SOF → Sright.
- In Sright, pulse `col_right` for 1 cycle mid-frame → Sbounce_from_right at next SOF. A `col_left` pulse during the bounce is ignored. Return to Sidle exactly 8 SOFs later.
- `col_top` and `col_deadly` pulsed in the same frame → Sdie with `lives_left` 3→2. Return to Sidle after 60 SOFs.
- Three deaths in sequence → after the third die period, `state`=Sreset, `lives_left`=0, `game_over`=1. `start_game` at the next SOF → Sidle, `lives_left`=3.
- Assert `resetN`=0 at frame 4 of a bounce → `state`=Sreset immediately. After release, no transition occurs without `start_game`.
